// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Holds the commit-stage record and the one-hot helper used for the pending mask.
package rf_pkg;

   localparam int RF_ADDR_W   = 5;
   localparam int RF_DATA_W   = 32;
   localparam int RF_NUM_REGS = 32;
   localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = 5'd0;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } rf_wr_t;

   function automatic logic [RF_NUM_REGS-1:0] rf_onehot(input logic [RF_ADDR_W-1:0] a);
      logic [RF_NUM_REGS-1:0] v;
      v    = '0;
      v[a] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rf_write_arbiter_chk.sv
// Protocol checker for the arbiter's requester interface and grant properties.
// Simulation-only assertions; instantiate alongside rf_write_arbiter.
module rf_write_arbiter_chk #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32
) (
   input logic                      clk,
   input logic                      rst,
   input logic [NUM_REQ-1:0]        req_valid,
   input logic [NUM_REQ-1:0]        req_ready,
   input logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input logic [NUM_REQ*DATA_W-1:0] req_data,
   input logic                      rf_we,
   input logic [ADDR_W-1:0]         rf_addr
);

   a_ready_onehot0: assert property (@(posedge clk) $onehot0(req_ready))
      else $error("req_ready not one-hot");

   a_ready_needs_valid: assert property (@(posedge clk) (req_ready & ~req_valid) == '0)
      else $error("ready without valid");

   a_no_x0_write: assert property (@(posedge clk) disable iff (rst) rf_we |-> (rf_addr != '0))
      else $error("write enable to x0");

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      a_hold: assert property (@(posedge clk) disable iff (rst)
         (req_valid[i] && !req_ready[i]) |=>
            (req_valid[i] && $stable(req_addr[i*ADDR_W +: ADDR_W]) &&
             $stable(req_data[i*DATA_W +: DATA_W])))
         else $error("requester %0d dropped or changed a pending request", i);
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ. The pointer itself lives in the caller.
module rr_arbiter #(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx,
   output logic                       any
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0] idx_s;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx_s     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_s = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (!any && req[idx_s]) begin
            grant[idx_s] = 1'b1;
            grant_idx    = idx_s;
            any          = 1'b1;
         end else begin
            any = any;
         end
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between NUM_REQ writeback sources
// through round-robin arbitration and a one-entry registered commit stage.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = RF_ADDR_W,
   parameter int DATA_W  = RF_DATA_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        rf_we,
   output logic [ADDR_W-1:0]           rf_addr,
   output logic [DATA_W-1:0]           rf_wdata,
   output logic [(2**ADDR_W)-1:0]      pending_mask,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]     grant_s;
   logic [IDX_W-1:0]       grant_idx_s;
   logic                   any_s;
   logic                   xfer_s;

   logic [IDX_W-1:0]       ptr_q, ptr_d;
   rf_wr_t                 stage_q, stage_d;
   logic                   we_q, we_d;
   logic [IDX_W-1:0]       gid_q, gid_d;
   logic [(2**ADDR_W)-1:0] pmask_q, pmask_d;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req       (req_valid),
      .ptr       (ptr_q),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .any       (any_s)
   );

   // Grant is a pure function of valid/ptr/rst, so ready never looks at payload.
   assign req_ready = rst ? '0 : grant_s;
   assign xfer_s    = any_s & ~rst;

   always_comb begin
      ptr_d   = ptr_q;
      stage_d = stage_q;
      we_d    = 1'b0;
      gid_d   = '0;
      pmask_d = '0;
      if (xfer_s) begin
         stage_d.addr = req_addr[int'(grant_idx_s)*ADDR_W +: ADDR_W];
         stage_d.data = req_data[int'(grant_idx_s)*DATA_W +: DATA_W];
         gid_d        = grant_idx_s;
         // x0 is architecturally read-only: complete the handshake but suppress the write.
         we_d         = (stage_d.addr != RF_ZERO_REG);
         pmask_d      = we_d ? rf_onehot(stage_d.addr) : '0;
         ptr_d        = (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + IDX_W'(1);
      end else begin
         ptr_d = ptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= '0;
         stage_q <= '0;
         we_q    <= 1'b0;
         gid_q   <= '0;
         pmask_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         stage_q <= stage_d;
         we_q    <= we_d;
         gid_q   <= gid_d;
         pmask_q <= pmask_d;
      end
   end

   assign rf_we        = we_q;
   assign rf_addr      = stage_q.addr;
   assign rf_wdata     = stage_q.data;
   assign grant_id     = gid_q;
   assign pending_mask = pmask_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized self-checking bench for rf_write_arbiter against a request-list
// reference model with its own register-file image.
module tb_rf_write_arbiter;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic            rf_we;
   logic [AW-1:0]   rf_addr;
   logic [DW-1:0]   rf_wdata;
   logic [31:0]     pending_mask;
   logic [1:0]      grant_id;

   always #5 clk = ~clk;

   rf_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(req_ready), .rf_we(rf_we),
      .rf_addr(rf_addr), .rf_wdata(rf_wdata), .pending_mask(pending_mask),
      .grant_id(grant_id)
   );

   rf_write_arbiter_chk #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) u_chk (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .rf_we(rf_we), .rf_addr(rf_addr)
   );

   // Register file fed by the DUT write port.
   logic [31:0] tb_rf [32] = '{default: 32'd0};
   always @(posedge clk) if (rf_we) tb_rf[rf_addr] <= rf_wdata;

   function automatic logic [31:0] rf_read(input int a);
      return (a == 0) ? 32'd0 : tb_rf[a];
   endfunction

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model state.
   bit          pv [N];
   logic [4:0]  pa [N];
   logic [31:0] pd [N];
   int          ptr_m = 0;
   logic        exp_we = 1'b0;
   logic [4:0]  exp_addr = '0;
   logic [31:0] exp_data = '0;
   int          exp_gid = 0;
   logic [31:0] exp_rf [32] = '{default: 32'd0};
   int          new_pct = 0;
   int          last_g = -1;
   int          obs_cnt [N];

   task automatic new_reqs();
      for (int i = 0; i < N; i++) begin
         if (!pv[i] && ($urandom_range(0, 99) < new_pct)) begin
            pv[i] = 1'b1;
            pa[i] = 5'($urandom_range(0, 31));
            pd[i] = $urandom;
         end
      end
   endtask

   task automatic step(input bit do_rst);
      int g;
      logic [N-1:0] exp_rdy;
      logic [31:0]  exp_pm;
      new_reqs();
      @(negedge clk);
      rst = do_rst;
      for (int i = 0; i < N; i++) begin
         req_valid[i]            = pv[i];
         req_addr[i*AW +: AW]    = pa[i];
         req_data[i*DW +: DW]    = pd[i];
      end
      #1;
      g = -1;
      if (!do_rst) begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && pv[(ptr_m + k) % N]) g = (ptr_m + k) % N;
         end
      end
      exp_rdy = (g >= 0) ? N'(1 << g) : '0;
      check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
      for (int i = 0; i < N; i++) obs_cnt[i] += int'(req_ready[i]);
      last_g = g;
      // The register file captures the currently committed write at this edge.
      if (exp_we) exp_rf[exp_addr] = exp_data;
      if (do_rst) begin
         exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_gid = 0; ptr_m = 0;
      end else if (g >= 0) begin
         exp_we   = (pa[g] != 5'd0);
         exp_addr = pa[g];
         exp_data = pd[g];
         exp_gid  = g;
         ptr_m    = (g + 1) % N;
         pv[g]    = 1'b0;
      end else begin
         exp_we = 1'b0; exp_gid = 0;
      end
      exp_pm = exp_we ? (32'd1 << exp_addr) : 32'd0;
      @(posedge clk);
      #1;
      check_eq("rf_we", 64'(rf_we), 64'(exp_we));
      check_eq("rf_addr", 64'(rf_addr), 64'(exp_addr));
      check_eq("rf_wdata", 64'(rf_wdata), 64'(exp_data));
      check_eq("grant_id", 64'(grant_id), 64'(exp_gid));
      check_eq("pending_mask", 64'(pending_mask), 64'(exp_pm));
   endtask

   task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
      pv[i] = 1'b1; pa[i] = a; pd[i] = d;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         pv[i] = 1'b0; pa[i] = '0; pd[i] = '0; obs_cnt[i] = 0;
      end

      // Reset with every requester valid, then fair rotation under full load.
      new_pct = 100;
      for (int c = 0; c < 3; c++) step(1'b1);
      for (int i = 0; i < N; i++) obs_cnt[i] = 0;
      step(1'b0);
      check_eq("first_grant_after_rst", 64'(last_g), 64'd0);
      for (int c = 0; c < 8; c++) step(1'b0);
      for (int i = 0; i < N; i++) check_eq("fair_count", 64'(obs_cnt[i]), 64'd3);

      new_pct = 0;
      for (int c = 0; c < 3; c++) step(1'b0);

      // Single request from requester 1.
      set_req(1, 5'd5, 32'hDEADBEEF);
      step(1'b0);
      check_eq("single_grant", 64'(last_g), 64'd1);
      check_eq("single_mask", 64'(pending_mask), 64'h20);

      // ptr now 2; only 0 and 1 valid: wrap to 0, then 1.
      set_req(0, 5'd7, 32'h0000_0007);
      set_req(1, 5'd8, 32'h0000_0008);
      step(1'b0);
      check_eq("wrap_grant0", 64'(last_g), 64'd0);
      step(1'b0);
      check_eq("wrap_grant1", 64'(last_g), 64'd1);

      // Write to x0 is accepted but never reaches the register file.
      set_req(2, 5'd0, 32'h0000_1234);
      step(1'b0);
      check_eq("x0_gid", 64'(grant_id), 64'd2);
      check_eq("x0_we", 64'(rf_we), 64'd0);
      step(1'b0);
      check_eq("x0_read", 64'(rf_read(0)), 64'd0);

      // Reset mid-operation: ptr advanced to 1, then reset returns it to 0.
      set_req(0, 5'd9, 32'hCAFE_0009);
      step(1'b0);
      set_req(0, 5'd10, 32'hCAFE_000A);
      set_req(1, 5'd11, 32'hCAFE_000B);
      step(1'b1);
      check_eq("midrst_we", 64'(rf_we), 64'd0);
      step(1'b0);
      check_eq("midrst_ptr0", 64'(last_g), 64'd0);
      step(1'b0);

      // Randomized traffic with occasional resets.
      new_pct = 50;
      for (int c = 0; c < 400; c++) step($urandom_range(0, 39) == 0);

      new_pct = 0;
      for (int c = 0; c < 5; c++) step(1'b0);
      for (int r = 0; r < 32; r++) check_eq($sformatf("rf[%0d]", r), 64'(rf_read(r)), 64'(exp_rf[r]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
